// File: rtl/dot_product_8.sv
// Streaming 8x8 unsigned dot product: accumulates LEN operand products, then presents the sum.
// Optional DOT_EARLY_LAST_EN adds in_last so a vector may end before LEN beats.
module dot_product_8 #(
  parameter  int WORDLEN = 8,
  parameter  int LEN     = 4,
  parameter  int ACCW    = 2*WORDLEN + $clog2(LEN+1),
  localparam int CW      = $clog2(LEN+1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WORDLEN-1:0] in_a,
  input  logic [WORDLEN-1:0] in_b,
`ifdef DOT_EARLY_LAST_EN
  input  logic               in_last,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACCW-1:0]    out_sum,
  output logic [CW-1:0]      out_beats
);

  typedef enum logic [1:0] {ACC, DRAIN, HOLD} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        acnt_q, acnt_d;
  logic [ACCW-1:0]      acc_q, acc_d;
  logic [WORDLEN-1:0]   op_a_q, op_a_d, op_b_q, op_b_d;
  logic                 op_valid_q, op_valid_d;
  logic                 op_last_q, op_last_d;
  logic                 out_valid_q, out_valid_d;
  logic [ACCW-1:0]      out_sum_q, out_sum_d;
  logic [CW-1:0]        out_beats_q, out_beats_d;

  logic                 accept;
  logic                 beat_last;
  logic [2*WORDLEN-1:0] mult_p;
  logic [ACCW-1:0]      product;

  // Mult_8 stage: purely combinational 8x8 -> 16 on the registered operands
  assign mult_p  = op_a_q * op_b_q;
  assign product = ACCW'(mult_p);

  assign in_ready  = (state_q == ACC) & ~rst;
  assign accept    = in_valid & in_ready;
`ifdef DOT_EARLY_LAST_EN
  assign beat_last = (acnt_q == CW'(LEN-1)) | in_last;
`else
  assign beat_last = (acnt_q == CW'(LEN-1));
`endif

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_beats = out_beats_q;

  always_comb begin
    state_d     = state_q;
    acnt_d      = acnt_q;
    acc_d       = acc_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    op_valid_d  = accept;
    op_last_d   = accept & beat_last;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_beats_d = out_beats_q;

    if (accept) begin
      op_a_d = in_a;
      op_b_d = in_b;
      acnt_d = acnt_q + CW'(1);
    end

    // acnt_q already includes the last beat when it reaches the multiply stage
    if (op_valid_q) begin
      if (op_last_q) begin
        out_sum_d   = acc_q + product;
        out_beats_d = acnt_q;
        out_valid_d = 1'b1;
        acc_d       = '0;
      end else begin
        acc_d = acc_q + product;
      end
    end

    case (state_q)
      ACC: begin
        if (accept && beat_last) state_d = DRAIN;
      end
      DRAIN: begin
        if (op_valid_q && op_last_q) state_d = HOLD;
      end
      HOLD: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          acnt_d      = '0;
          state_d     = ACC;
        end
      end
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACC;
      acnt_q      <= '0;
      acc_q       <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_valid_q  <= 1'b0;
      op_last_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_beats_q <= '0;
    end else begin
      state_q     <= state_d;
      acnt_q      <= acnt_d;
      acc_q       <= acc_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_valid_q  <= op_valid_d;
      op_last_q   <= op_last_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_beats_q <= out_beats_d;
    end
  end

endmodule

// File: tb/tb_dot_product_8.sv
// Bench for dot_product_8: transaction-level model checked every cycle, directed vectors plus random traffic.
// Define DOT_EARLY_LAST_EN to also exercise early vector termination.
module tb_dot_product_8;
  localparam int WORDLEN = 8;
  localparam int LEN     = 4;
  localparam int ACCW    = 2*WORDLEN + $clog2(LEN+1);
  localparam int CW      = $clog2(LEN+1);
`ifdef DOT_EARLY_LAST_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [WORDLEN-1:0] in_a = '0;
  logic [WORDLEN-1:0] in_b = '0;
  logic               in_last = 1'b0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic [ACCW-1:0]    out_sum;
  logic [CW-1:0]      out_beats;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rdy_mode = 0;

  // transaction model state
  longint m_sum = 0;
  int     m_beats = 0;
  bit     m_busy = 0;
  bit     m_pend = 0;
  longint m_res = 0;
  int     m_resb = 0;
  bit     m_outv = 0;
  longint m_osum = 0;
  int     m_obeats = 0;
  int     last_done_cyc = 0;
  int     last_rise_cyc = 0;
  bit     prev_outv = 0;
  longint got_sum[$];
  int     got_beats[$];

  dot_product_8 #(.LEN(LEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
`ifdef DOT_EARLY_LAST_EN
    .in_last   (in_last),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_beats (out_beats)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  // Per-cycle compare against the model, then advance the model by this cycle's handshakes
  always @(negedge clk) begin
    bit exp_rdy;
    cyc++;
    if (rst) begin
      check("in_ready_in_rst", in_ready, 0);
      m_sum = 0; m_beats = 0; m_busy = 0; m_pend = 0;
      m_outv = 0; m_osum = 0; m_obeats = 0; prev_outv = 0;
    end else begin
      exp_rdy = !m_busy;
      check("in_ready", in_ready, exp_rdy);
      check("out_valid", out_valid, m_outv);
      check("out_sum", out_sum, m_osum);
      check("out_beats", out_beats, m_obeats);
      if (out_valid && !prev_outv) last_rise_cyc = cyc;
      prev_outv = out_valid;
      if (out_valid && out_ready) begin
        got_sum.push_back(out_sum);
        got_beats.push_back(out_beats);
      end
      if (m_outv && out_ready) begin
        m_outv = 0;
        m_busy = 0;
      end
      if (m_pend) begin
        m_outv = 1; m_osum = m_res; m_obeats = m_resb; m_pend = 0;
      end
      if (in_valid && exp_rdy) begin
        m_sum += longint'(in_a) * longint'(in_b);
        m_beats++;
        if (m_beats == LEN || (EARLY && in_last)) begin
          m_res = m_sum; m_resb = m_beats;
          m_sum = 0; m_beats = 0;
          m_pend = 1; m_busy = 1;
          last_done_cyc = cyc;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(1, 0));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Driver tasks start and end just after a rising edge
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic last, input int max_bubble);
    bit ok;
    int n;
    n = (max_bubble > 0) ? $urandom_range(max_bubble, 0) : 0;
    repeat (n) begin @(posedge clk); #1; end
    in_valid = 1'b1; in_a = a; in_b = b; in_last = last;
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0; in_last = 1'b0;
    check("send_accept", ok, 1);
  endtask

  task automatic wait_outs(input int n);
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (got_sum.size() >= n) break;
    end
    check("wait_out", got_sum.size() >= n, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) break;
    end
    check("wait_valid", out_valid, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    int base;
    logic last;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_sum", out_sum, 0);
    check("reset_out_beats", out_beats, 0);
    @(posedge clk); #1;

    // basic vector and latency
    base = got_sum.size();
    send(1, 1, 0, 0); send(2, 3, 0, 0); send(4, 5, 0, 0); send(6, 7, 0, 0);
    wait_outs(base + 1);
    check("t1_sum", got_sum[base], 69);
    check("t1_beats", got_beats[base], 4);
    check("t1_latency", last_rise_cyc - last_done_cyc, 2);
    @(negedge clk);
    check("t1_single_cycle", out_valid, 0);
    @(posedge clk); #1;

    // full-scale operands
    base = got_sum.size();
    repeat (4) send(255, 255, 0, 0);
    wait_outs(base + 1);
    check("t2_sum", got_sum[base], 260100);

    // back-to-back vectors
    base = got_sum.size();
    send(1, 1, 0, 0); send(2, 3, 0, 0); send(4, 5, 0, 0); send(6, 7, 0, 0);
    repeat (4) send(3, 3, 0, 0);
    wait_outs(base + 2);
    check("t4_sum0", got_sum[base], 69);
    check("t4_sum1", got_sum[base+1], 36);

    // output backpressure
    rdy_mode = 2;
    idle(2);
    base = got_sum.size();
    repeat (4) send(2, 2, 0, 0);
    wait_valid();
    in_valid = 1'b1; in_a = 9; in_b = 9;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t3_in_ready_low", in_ready, 0);
      check("t3_sum_stable", out_sum, 16);
      check("t3_beats_stable", out_beats, 4);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rdy_mode = 0;
    wait_outs(base + 1);
    check("t3_sum", got_sum[base], 16);
    @(negedge clk);
    check("t3_ready_after", in_ready, 1);
    @(posedge clk); #1;

    // reset mid-vector, then reset while holding a result
    send(1, 1, 0, 0); send(1, 1, 0, 0);
    rst = 1'b1; idle(2); rst = 1'b0;
    rdy_mode = 2;
    repeat (4) send(5, 5, 0, 0);
    wait_valid();
    rst = 1'b1; idle(2); rst = 1'b0;
    rdy_mode = 0;
    base = got_sum.size();
    repeat (4) send(1, 2, 0, 0);
    wait_outs(base + 1);
    check("t5_sum", got_sum[base], 8);

`ifdef DOT_EARLY_LAST_EN
    base = got_sum.size();
    send(10, 10, 0, 0); send(5, 4, 1, 0);
    wait_outs(base + 1);
    check("t6_sum", got_sum[base], 120);
    check("t6_beats", got_beats[base], 2);
`endif

    // random traffic with bubbles and backpressure
    rdy_mode = 1;
    base = got_sum.size();
    for (int v = 0; v < 40; v++) begin
      for (int j = 0; j < LEN; j++) begin
        last = EARLY && (j != LEN-1) && ($urandom_range(4, 0) == 0);
        send(8'($urandom), 8'($urandom), last, 3);
        if (last) break;
      end
    end
    wait_outs(base + 40);
    rdy_mode = 0;
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
